// File: rtl/axi_bridge_mo.sv
// SRAM-like to AXI3 master bridge for N_PORT requesters.
// Several reads may be in flight, but only one write; reads that hit the pending write's word stall.
//
//  state  | meaning
//  W_IDLE | no write in flight, a write may be accepted
//  W_SEND | AW and/or W channel still waiting for its handshake
//  W_RESP | both channels done, waiting for the B response
module axi_bridge_mo #(
    parameter int N_PORT   = 2,
    parameter int RD_OUTST = 4,
    parameter int CNT_W    = 3
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [N_PORT-1:0]     req_i,
    input  logic [N_PORT-1:0]     wr_i,
    input  logic [2*N_PORT-1:0]   size_i,
    input  logic [4*N_PORT-1:0]   wstrb_i,
    input  logic [32*N_PORT-1:0]  addr_i,
    input  logic [32*N_PORT-1:0]  wdata_i,
    output logic [N_PORT-1:0]     addr_ok_o,
    output logic [N_PORT-1:0]     data_ok_o,
    output logic [32*N_PORT-1:0]  rdata_o,

    output logic [3:0]            arid_o,
    output logic [31:0]           araddr_o,
    output logic [3:0]            arlen_o,
    output logic [2:0]            arsize_o,
    output logic [1:0]            arburst_o,
    output logic [1:0]            arlock_o,
    output logic [3:0]            arcache_o,
    output logic [2:0]            arprot_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,

    input  logic [3:0]            rid_i,
    input  logic [31:0]           rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,

    output logic [3:0]            awid_o,
    output logic [31:0]           awaddr_o,
    output logic [3:0]            awlen_o,
    output logic [2:0]            awsize_o,
    output logic [1:0]            awburst_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,

    output logic [3:0]            wid_o,
    output logic [31:0]           wdata_o,
    output logic [3:0]            wstrb_o,
    output logic                  wlast_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,

    input  logic [3:0]            bid_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o
);

    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wstate_t;

    wstate_t           wstate_q;
    logic              arvalid_q, awvalid_q, wvalid_q, bready_q, rready_q;
    logic [3:0]        arid_q, awid_q;
    logic [31:0]       araddr_q, awaddr_q, wdata_q;
    logic [2:0]        arsize_q, awsize_q;
    logic [3:0]        wstrb_q;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;

    int                rd_sel, wr_sel;
    logic              rd_any, wr_any, rd_acc, wr_acc, hazard;
    logic              r_hs, b_hs;
    logic              unused_ok;

    assign unused_ok = ^{rresp_i, rlast_i, bresp_i};

    // Highest index wins: later loop iterations overwrite earlier ones.
    always_comb begin
        rd_any = 1'b0;
        wr_any = 1'b0;
        rd_sel = 0;
        wr_sel = 0;
        for (int p = 0; p < N_PORT; p++) begin
            if (req_i[p] && !wr_i[p]) begin
                rd_any = 1'b1;
                rd_sel = p;
            end
            if (req_i[p] && wr_i[p]) begin
                wr_any = 1'b1;
                wr_sel = p;
            end
        end
    end

    assign hazard = (wstate_q != W_IDLE) && (addr_i[32*rd_sel+2 +: 30] == awaddr_q[31:2]);
    assign wr_acc = wr_any && (wstate_q == W_IDLE) && (rd_cnt_q == '0) && !arvalid_q;
    assign rd_acc = rd_any && !arvalid_q && (rd_cnt_q < CNT_W'(RD_OUTST)) && !wr_acc && !hazard;
    assign r_hs   = rvalid_i && rready_q;
    assign b_hs   = bvalid_i && bready_q;

    always_comb begin
        addr_ok_o = '0;
        data_ok_o = '0;
        rdata_o   = '0;
        for (int p = 0; p < N_PORT; p++) begin
            addr_ok_o[p] = (rd_acc && rd_sel == p) || (wr_acc && wr_sel == p);
            data_ok_o[p] = (r_hs && rid_i == 4'(p)) || (b_hs && bid_i == 4'(p));
            if (r_hs && rid_i == 4'(p))
                rdata_o[32*p +: 32] = rdata_i;
        end
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        case ({rd_acc, r_hs})
            2'b10:   rd_cnt_d = rd_cnt_q + 1'b1;
            2'b01:   rd_cnt_d = rd_cnt_q - 1'b1;
            default: rd_cnt_d = rd_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rd_cnt_q  <= '0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arsize_q  <= '0;
        end else begin
            rready_q <= 1'b1;
            rd_cnt_q <= rd_cnt_d;
            if (rd_acc) begin
                arvalid_q <= 1'b1;
                arid_q    <= 4'(rd_sel);
                araddr_q  <= addr_i[32*rd_sel +: 32];
                arsize_q  <= {1'b0, size_i[2*rd_sel +: 2]};
            end else if (arready_i) begin
                arvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wstate_q  <= W_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awid_q    <= '0;
            awaddr_q  <= '0;
            awsize_q  <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (wr_acc) begin
                        wstate_q  <= W_SEND;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        awid_q    <= 4'(wr_sel);
                        awaddr_q  <= addr_i[32*wr_sel +: 32];
                        awsize_q  <= {1'b0, size_i[2*wr_sel +: 2]};
                        wstrb_q   <= wstrb_i[4*wr_sel +: 4];
                        wdata_q   <= wdata_i[32*wr_sel +: 32];
                    end
                end
                W_SEND: begin
                    if (awready_i) awvalid_q <= 1'b0;
                    if (wready_i)  wvalid_q  <= 1'b0;
                    if ((!awvalid_q || awready_i) && (!wvalid_q || wready_i)) begin
                        wstate_q <= W_RESP;
                        bready_q <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (bvalid_i) begin
                        wstate_q <= W_IDLE;
                        bready_q <= 1'b0;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    assign arid_o    = arid_q;
    assign araddr_o  = araddr_q;
    assign arsize_o  = arsize_q;
    assign arvalid_o = arvalid_q;
    assign arlen_o   = 4'd0;
    assign arburst_o = 2'b01;
    assign arlock_o  = 2'b00;
    assign arcache_o = 4'd0;
    assign arprot_o  = 3'd0;
    assign rready_o  = rready_q;

    assign awid_o    = awid_q;
    assign awaddr_o  = awaddr_q;
    assign awsize_o  = awsize_q;
    assign awvalid_o = awvalid_q;
    assign awlen_o   = 4'd0;
    assign awburst_o = 2'b01;
    assign wid_o     = awid_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;
    assign wlast_o   = 1'b1;
    assign wvalid_o  = wvalid_q;
    assign bready_o  = bready_q;

endmodule

// File: tb/tb_axi_bridge_mo.sv
// Directed bench for axi_bridge_mo; the AXI slave side is driven by hand, step by step.
module tb_axi_bridge_mo;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, wr;
    logic [3:0]  size;
    logic [7:0]  wstrb;
    logic [63:0] addr, wdata;
    logic [1:0]  addr_ok, data_ok;
    logic [63:0] rdata;
    logic [3:0]  arid, arlen, arcache, awid, awlen, wid, wstrb_o, rid, bid;
    logic [31:0] araddr, awaddr, wdata_o, r_data;
    logic [2:0]  arsize, arprot, awsize;
    logic [1:0]  arburst, arlock, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi_bridge_mo dut (
        .clk(clk), .reset(reset),
        .req_i(req), .wr_i(wr), .size_i(size), .wstrb_i(wstrb), .addr_i(addr), .wdata_i(wdata),
        .addr_ok_o(addr_ok), .data_ok_o(data_ok), .rdata_o(rdata),
        .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize), .arburst_o(arburst),
        .arlock_o(arlock), .arcache_o(arcache), .arprot_o(arprot), .arvalid_o(arvalid), .arready_i(arready),
        .rid_i(rid), .rdata_i(r_data), .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid), .rready_o(rready),
        .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize), .awburst_o(awburst),
        .awvalid_o(awvalid), .awready_i(awready),
        .wid_o(wid), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
        .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req = '0; wr = '0; size = '0; wstrb = '0; addr = '0; wdata = '0;
        arready = 1'b1; rid = '0; r_data = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
        step(); step();
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_rready", rready, 0);
        chk("const_arburst", arburst, 2'b01);
        chk("const_wlast", wlast, 1);
        reset = 1'b0;
        step();
        chk("rready_after_rst", rready, 1);

        // single port0 read, slave answers one cycle after AR handshake
        req = 2'b01; size[1:0] = 2'd2; addr[31:0] = 32'h1c00_0000;
        #1 chk("t1_addr_ok", addr_ok, 2'b01);
        step();
        req = 2'b00;
        chk("t1_arvalid", arvalid, 1);
        chk("t1_araddr", araddr, 32'h1c00_0000);
        chk("t1_arid", arid, 0);
        chk("t1_arsize", arsize, 3'd2);
        step();
        chk("t1_ar_drop", arvalid, 0);
        rvalid = 1'b1; rid = 4'd0; r_data = 32'hdead_beef;
        #1 chk("t1_data_ok", data_ok, 2'b01);
        chk("t1_rdata", rdata, 64'h0000_0000_dead_beef);
        step();
        rvalid = 1'b0;

        // both ports read in the same cycle, port1 wins
        arready = 1'b0;
        req = 2'b11; wr = 2'b00; addr = {32'h0000_0300, 32'h0000_0200}; size = 4'b1010;
        #1 chk("t2_addr_ok_both", addr_ok, 2'b10);
        step();
        req = 2'b01;
        #1 chk("t2_arid1", arid, 1);
        chk("t2_araddr1", araddr, 32'h300);
        chk("t2_blocked_by_arvalid", addr_ok, 2'b00);
        step();
        chk("t2_ar_hold", arvalid, 1);
        chk("t2_araddr_hold", araddr, 32'h300);
        arready = 1'b1;
        step();
        chk("t2_port0_now", addr_ok, 2'b01);
        step();
        req = 2'b00;
        chk("t2_arid0", arid, 0);
        chk("t2_araddr0", araddr, 32'h200);
        step();

        // out-of-order responses
        rvalid = 1'b1; rid = 4'd1; r_data = 32'h1111_1111;
        #1 chk("t5_data_ok1", data_ok, 2'b10);
        chk("t5_rdata1", rdata, 64'h1111_1111_0000_0000);
        step();
        rid = 4'd0; r_data = 32'h2222_2222;
        #1 chk("t5_data_ok0", data_ok, 2'b01);
        chk("t5_rdata0", rdata, 64'h0000_0000_2222_2222);
        step();
        rvalid = 1'b0;

        // outstanding limit with rvalid held low
        req = 2'b01; size[1:0] = 2'd2;
        for (int i = 0; i < 4; i++) begin
            addr[31:0] = 32'h1000 + 32'(4 * i);
            #1 chk($sformatf("t3_accept%0d", i), addr_ok, 2'b01);
            step();
            chk($sformatf("t3_araddr%0d", i), araddr, 32'h1000 + 32'(4 * i));
            step();
        end
        addr[31:0] = 32'h2000;
        #1 chk("t3_fifth_blocked", addr_ok, 2'b00);
        step();
        chk("t3_fifth_still_blocked", addr_ok, 2'b00);
        chk("t3_no_arvalid", arvalid, 0);
        rvalid = 1'b1; rid = 4'd0; r_data = 32'h3333_3333;
        #1 chk("t3_blocked_during_r", addr_ok, 2'b00);
        chk("t3_r_data_ok", data_ok, 2'b01);
        step();
        rvalid = 1'b0;
        #1 chk("t3_fifth_after_r", addr_ok, 2'b01);
        req = 2'b00;
        step();
        rvalid = 1'b1;
        step(); step(); step();
        rvalid = 1'b0;

        // port1 write, W handshakes 3 cycles before AW; overlapping port0 read stalls
        awready = 1'b0; wready = 1'b1;
        req = 2'b10; wr = 2'b10; size[3:2] = 2'd1; wstrb[7:4] = 4'b0011;
        addr[63:32] = 32'h0000_0100; wdata[63:32] = 32'ha5a5_a5a5;
        #1 chk("t4_addr_ok", addr_ok, 2'b10);
        step();
        req = 2'b01; wr = 2'b00; addr[31:0] = 32'h0000_0102;
        chk("t4_awvalid", awvalid, 1);
        chk("t4_wvalid", wvalid, 1);
        chk("t4_awaddr", awaddr, 32'h100);
        chk("t4_awsize", awsize, 3'd1);
        chk("t4_wstrb", wstrb_o, 4'b0011);
        chk("t4_wdata", wdata_o, 32'ha5a5_a5a5);
        chk("t4_awid", awid, 1);
        chk("t4_wid", wid, 1);
        #1 chk("t4_rd_stall_a", addr_ok, 2'b00);
        step();
        wready = 1'b0;
        chk("t4_w_done", wvalid, 0);
        chk("t4_aw_wait", awvalid, 1);
        chk("t4_rd_stall_b", addr_ok, 2'b00);
        step();
        chk("t4_rd_stall_c", addr_ok, 2'b00);
        chk("t4_no_bready_yet", bready, 0);
        step();
        awready = 1'b1;
        step();
        awready = 1'b0;
        chk("t4_aw_done", awvalid, 0);
        chk("t4_bready", bready, 1);
        chk("t4_rd_stall_resp", addr_ok, 2'b00);
        bvalid = 1'b1; bid = 4'd1;
        #1 chk("t4_b_data_ok", data_ok, 2'b10);
        step();
        bvalid = 1'b0;
        chk("t4_bready_drop", bready, 0);
        #1 chk("t4_rd_released", addr_ok, 2'b01);
        step();
        req = 2'b00;
        step();
        rvalid = 1'b1; rid = 4'd0;
        step();
        rvalid = 1'b0;

        // reset during W_SEND; write beats a same-cycle read
        awready = 1'b0; wready = 1'b0;
        req = 2'b11; wr = 2'b10; addr = {32'h0000_0040, 32'h0000_0080};
        #1 chk("t6_write_wins", addr_ok, 2'b10);
        step();
        req = 2'b00; wr = 2'b00;
        chk("t6_awvalid", awvalid, 1);
        reset = 1'b1;
        step();
        chk("t6_rst_awvalid", awvalid, 0);
        chk("t6_rst_wvalid", wvalid, 0);
        chk("t6_rst_bready", bready, 0);
        reset = 1'b0;
        step();
        req = 2'b01; addr[31:0] = 32'h0000_0040;
        #1 chk("t6_addr_ok_again", addr_ok, 2'b01);
        step();
        req = 2'b00;
        chk("t6_arvalid", arvalid, 1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
